// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg -- shared UART FSM state encoding and default line parameters
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 50 MHz system clock, 115200 baud, 8N1 framing.
  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS    = 8;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// uart_bit_timer -- bit-period counter with terminal-count and half-count flags
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc,
  output logic half
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TC_VAL   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] count;

  // Self-clearing on terminal count keeps the counter inside its range even
  // if the owner forgets to clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc   = (count == TC_VAL);
  assign half = (count == HALF_VAL);

endmodule

`default_nettype wire

// File: rtl/uart_rx_lora.sv
// ============================================================================
// uart_rx_lora -- 8N1-style UART receiver, mid-bit sampling, break-safe restart
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_lora
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic                 sync1;
  logic                 rx_s;
  logic                 rx_s_d;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 break_flag;
  logic                 fall;
  logic                 timer_clear;
  logic                 tc;
  logic                 half;
  logic                 shift_en;
  logic                 idx_clear;
  logic                 done_set;
  logic                 err_set;

  // Synchronizer flops reset to the idle level so release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= rx;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d && !rx_s && !break_flag;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tc   (tc),
    .half (half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    shift_en    = 1'b0;
    idx_clear   = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (fall) begin
          state_next = START;
        end
      end
      START: begin
        if (half) begin
          timer_clear = 1'b1;
          if (!rx_s) begin
            idx_clear  = 1'b1;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tc) begin
          timer_clear = 1'b1;
          shift_en    = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tc) begin
          timer_clear = 1'b1;
          state_next  = IDLE;
          if (rx_s) begin
            done_set = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      break_flag <= 1'b0;
    end else begin
      rx_done   <= done_set;
      frame_err <= err_set;
      if (idx_clear) begin
        idx <= '0;
      end else if (shift_en) begin
        idx <= idx + 1'b1;
      end
      if (shift_en) begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (idx == IDX_W'(i)) begin
            shift_reg[i] <= rx_s;
          end
        end
      end
      if (done_set) begin
        rx_data <= shift_reg;
      end
      // A low stop bit may be a held break; wait for the line to go high first.
      if (err_set) begin
        break_flag <= 1'b1;
      end else if (state == IDLE && rx_s) begin
        break_flag <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_lora.sv
// ============================================================================
// tb_uart_rx_lora -- scoreboard bench for uart_rx_lora (16 clk/bit, 8 bits)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_lora;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx_lora #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_mis = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         done_cyc_last = 0;
  int         done_cyc_prev = 0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic       saw_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Even-numbered bits (start, d1, d3, ...) last pa cycles, odd ones pb.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pa, input int pb);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop, d, 1'b0};
    if (stop) begin
      e.is_err  = 1'b0;
      e.data    = d;
      last_good = d;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_good;
    end
    sb.push_back(e);
    for (int j = 0; j < 10; j++) begin
      rx = bits[j];
      wait_cyc((j % 2 == 0) ? pa : pb);
    end
  endtask

  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      check_val("pulse_exclusive", rx_done & frame_err, 0);
      check_val("sb_empty_at_pulse", (sb.size() == 0), 0);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_val("pulse_kind", frame_err, mon_e.is_err);
        check_val("rx_data", rx_data, mon_e.data);
      end
      if (rx_done) begin
        check_val("done_width", prev_done, 0);
        done_cnt++;
        done_cyc_prev = done_cyc_last;
        done_cyc_last = cyc;
      end
      if (frame_err) begin
        check_val("err_width", prev_err, 0);
        err_cnt++;
      end
    end
    prev_done <= rx_done;
    prev_err  <= frame_err;
  end

  initial begin
    logic [9:0] part;

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check_val("rst_rx_data", rx_data, 8'h00);
    check_val("rst_rx_done", rx_done, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(5);

    // Single nominal frame
    send_frame(8'hA5, 1'b1, 16, 16);
    wait_cyc(20);
    @(negedge clk);
    check_val("a5_done_cnt", done_cnt, 1);
    check_val("a5_err_cnt", err_cnt, 0);
    check_val("a5_busy_after", busy, 0);
    @(posedge clk);
    #1;

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 16, 16);
    send_frame(8'hFF, 1'b1, 16, 16);
    wait_cyc(20);
    @(negedge clk);
    check_val("b2b_done_cnt", done_cnt, 3);
    check_val("b2b_spacing", done_cyc_last - done_cyc_prev, 160);
    check_val("b2b_rx_data", rx_data, 8'hFF);
    @(posedge clk);
    #1;

    // Short low glitch on an idle line
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    check_val("glitch_busy_seen", saw_busy, 1);
    check_val("glitch_busy_after", busy, 0);
    check_val("glitch_done_cnt", done_cnt, 3);
    @(posedge clk);
    #1;

    // Low stop bit followed by a held break
    send_frame(8'h3C, 1'b0, 16, 16);
    wait_cyc(40);
    @(negedge clk);
    check_val("ferr_err_cnt", err_cnt, 1);
    check_val("ferr_busy_in_break", busy, 0);
    check_val("ferr_rx_data_kept", rx_data, 8'hFF);
    @(posedge clk);
    #1;
    rx = 1'b1;
    wait_cyc(30);
    @(negedge clk);
    check_val("ferr_busy_line_high", busy, 0);
    check_val("ferr_done_cnt", done_cnt, 3);
    @(posedge clk);
    #1;

    // Reset in the middle of data bit 3 of 0x55
    part = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 4; j++) begin
      rx = part[j];
      wait_cyc(16);
    end
    rx = part[4];
    wait_cyc(8);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_rx_data", rx_data, 8'h00);
    check_val("midrst_rx_done", rx_done, 0);
    check_val("midrst_frame_err", frame_err, 0);
    wait_cyc(2);
    rst = 1'b0;
    last_good = 8'h00;
    wait_cyc(30);
    @(negedge clk);
    check_val("postrst_busy", busy, 0);
    check_val("postrst_done_cnt", done_cnt, 3);
    @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, 16, 16);
    wait_cyc(20);
    @(negedge clk);
    check_val("postrst_81_data", rx_data, 8'h81);
    check_val("postrst_81_done_cnt", done_cnt, 4);
    @(posedge clk);
    #1;

    // Bit-rate skew: slow line, then a line averaging 15.5 clocks per bit
    send_frame(8'h96, 1'b1, 17, 17);
    wait_cyc(20);
    send_frame(8'h96, 1'b1, 16, 15);
    wait_cyc(20);
    @(negedge clk);
    check_val("skew_rx_data", rx_data, 8'h96);

    check_val("final_done_cnt", done_cnt, 6);
    check_val("final_err_cnt", err_cnt, 1);
    check_val("final_sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
